// File: rtl/rdlvl_initiator_if.sv
// DFI read-training signals between the controller-side sequencer (master) and the PHY (slave).
interface rdlvl_initiator_if #(
  parameter int IOG_DQS_LANES = 9
);
  // Handshake: a phase enable with its cs_n low is the request. It stays high until every
  // required lane has shown dfi_rdlvl_resp for at least one cycle. resp is sampled every
  // cycle, and rd_training_error is only meaningful on cycles where that lane's resp is high.
  logic                     dfi_rdlvl_gate_en;
  logic                     dfi_rdlvl_en;
  logic                     dfi_rdlvl_cs_0_n;
  logic                     dfi_rdlvl_cs_1_n;
  logic                     dfi_rddata_en_p0;
  logic                     dfi_rddata_en_p1;
  logic                     dfi_rddata_en_p2;
  logic                     dfi_rddata_en_p3;
  logic [IOG_DQS_LANES-1:0] dfi_rdlvl_resp;
  logic [IOG_DQS_LANES-1:0] rd_training_error;

  modport master (
    output dfi_rdlvl_gate_en, dfi_rdlvl_en, dfi_rdlvl_cs_0_n, dfi_rdlvl_cs_1_n,
    output dfi_rddata_en_p0, dfi_rddata_en_p1, dfi_rddata_en_p2, dfi_rddata_en_p3,
    input  dfi_rdlvl_resp, rd_training_error
  );

  modport slave (
    input  dfi_rdlvl_gate_en, dfi_rdlvl_en, dfi_rdlvl_cs_0_n, dfi_rdlvl_cs_1_n,
    input  dfi_rddata_en_p0, dfi_rddata_en_p1, dfi_rddata_en_p2, dfi_rddata_en_p3,
    output dfi_rdlvl_resp, rd_training_error
  );
endinterface

// File: rtl/rdlvl_initiator.sv
// Sequences DFI gate training then read-eye levelling for one rank, issuing periodic
// training reads and collecting per-lane responses and errors.
module rdlvl_initiator #(
  parameter int          IOG_DQS_LANES = 9,
  parameter logic [31:0] LANE_MASK     = 32'h1FF,
  parameter int          RD_GAP        = 8,
  parameter logic [15:0] TIMEOUT       = 16'hFFFF,
  parameter int          SETTLE        = 4
) (
  input  logic                     SCLK,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     rank_sel,
  input  logic                     skip_gate,
  rdlvl_initiator_if.master        dfi,
  output logic                     busy,
  output logic                     done,
  output logic                     fail,
  output logic                     timeout_err,
  output logic [IOG_DQS_LANES-1:0] fail_lanes,
  output logic [15:0]              read_count,
  output logic [2:0]               state_dbg
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    GATE         = 3'd1,
    GATE_SETTLE  = 3'd2,
    RDLVL        = 3'd3,
    RDLVL_SETTLE = 3'd4,
    DONE         = 3'd5
  } state_t;

  localparam logic [IOG_DQS_LANES-1:0] MASK        = LANE_MASK[IOG_DQS_LANES-1:0];
  localparam logic [7:0]               GAP_LOAD    = 8'(RD_GAP - 1);
  localparam logic [7:0]               SETTLE_LOAD = 8'(SETTLE - 1);
  localparam logic [15:0]              TMO_LAST    = TIMEOUT - 16'd1;

  state_t                   state;
  logic                     rank_q;
  logic [IOG_DQS_LANES-1:0] resp_seen;
  logic [7:0]               gap_cnt;
  logic [7:0]               settle_cnt;
  logic [15:0]              phase_timer;

  logic [IOG_DQS_LANES-1:0] seen_nx;
  logic [IOG_DQS_LANES-1:0] fl_nx;
  logic                     phase_done;
  logic [15:0]              rc_inc;

  // Include this cycle's responses so the enable drops on the cycle right after the last resp.
  assign seen_nx    = resp_seen | dfi.dfi_rdlvl_resp;
  assign fl_nx      = fail_lanes | (dfi.dfi_rdlvl_resp & dfi.rd_training_error);
  assign phase_done = ((seen_nx & MASK) == MASK);
  assign rc_inc     = (read_count == 16'hFFFF) ? read_count : read_count + 16'd1;
  assign state_dbg  = state;

  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      state                 <= IDLE;
      rank_q                <= 1'b0;
      resp_seen             <= '0;
      gap_cnt               <= '0;
      settle_cnt            <= '0;
      phase_timer           <= '0;
      dfi.dfi_rdlvl_gate_en <= 1'b0;
      dfi.dfi_rdlvl_en      <= 1'b0;
      dfi.dfi_rdlvl_cs_0_n  <= 1'b1;
      dfi.dfi_rdlvl_cs_1_n  <= 1'b1;
      dfi.dfi_rddata_en_p0  <= 1'b0;
      dfi.dfi_rddata_en_p1  <= 1'b0;
      dfi.dfi_rddata_en_p2  <= 1'b0;
      dfi.dfi_rddata_en_p3  <= 1'b0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      fail                  <= 1'b0;
      timeout_err           <= 1'b0;
      fail_lanes            <= '0;
      read_count            <= '0;
    end else begin
      dfi.dfi_rddata_en_p0 <= 1'b0;
      dfi.dfi_rddata_en_p1 <= 1'b0;
      dfi.dfi_rddata_en_p2 <= 1'b0;
      dfi.dfi_rddata_en_p3 <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            rank_q               <= rank_sel;
            busy                 <= 1'b1;
            done                 <= 1'b0;
            fail                 <= 1'b0;
            timeout_err          <= 1'b0;
            fail_lanes           <= '0;
            read_count           <= '0;
            resp_seen            <= '0;
            gap_cnt              <= GAP_LOAD;
            phase_timer          <= '0;
            dfi.dfi_rdlvl_cs_0_n <= rank_sel;
            dfi.dfi_rdlvl_cs_1_n <= !rank_sel;
            if (skip_gate) begin
              dfi.dfi_rdlvl_en <= 1'b1;
              state            <= RDLVL;
            end else begin
              dfi.dfi_rdlvl_gate_en <= 1'b1;
              state                 <= GATE;
            end
          end
        end

        GATE, RDLVL: begin
          resp_seen   <= seen_nx;
          fail_lanes  <= fl_nx;
          phase_timer <= phase_timer + 16'd1;
          if (phase_done) begin
            dfi.dfi_rdlvl_gate_en <= 1'b0;
            dfi.dfi_rdlvl_en      <= 1'b0;
            dfi.dfi_rdlvl_cs_0_n  <= 1'b1;
            dfi.dfi_rdlvl_cs_1_n  <= 1'b1;
            settle_cnt            <= SETTLE_LOAD;
            state                 <= (state == GATE) ? GATE_SETTLE : RDLVL_SETTLE;
          end else if (phase_timer == TMO_LAST) begin
            // Timeout skips settle and reports straight away.
            dfi.dfi_rdlvl_gate_en <= 1'b0;
            dfi.dfi_rdlvl_en      <= 1'b0;
            dfi.dfi_rdlvl_cs_0_n  <= 1'b1;
            dfi.dfi_rdlvl_cs_1_n  <= 1'b1;
            timeout_err           <= 1'b1;
            fail                  <= 1'b1;
            done                  <= 1'b1;
            busy                  <= 1'b0;
            state                 <= DONE;
          end else if (gap_cnt == 8'd0) begin
            dfi.dfi_rddata_en_p0 <= 1'b1;
            dfi.dfi_rddata_en_p1 <= 1'b1;
            dfi.dfi_rddata_en_p2 <= 1'b1;
            dfi.dfi_rddata_en_p3 <= 1'b1;
            gap_cnt              <= GAP_LOAD;
            read_count           <= rc_inc;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end

        GATE_SETTLE: begin
          fail_lanes <= fl_nx;
          if (settle_cnt != 8'd0) begin
            settle_cnt <= settle_cnt - 8'd1;
          end else if (|(fl_nx & MASK)) begin
            fail  <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            resp_seen            <= '0;
            gap_cnt              <= GAP_LOAD;
            phase_timer          <= '0;
            dfi.dfi_rdlvl_en     <= 1'b1;
            dfi.dfi_rdlvl_cs_0_n <= rank_q;
            dfi.dfi_rdlvl_cs_1_n <= !rank_q;
            state                <= RDLVL;
          end
        end

        RDLVL_SETTLE: begin
          fail_lanes <= fl_nx;
          if (settle_cnt != 8'd0) begin
            settle_cnt <= settle_cnt - 8'd1;
          end else begin
            fail  <= |(fl_nx & MASK);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rdlvl_initiator.sv
// Directed bench for rdlvl_initiator: a reactive PHY responder, per-cycle protocol monitor
// and hand-computed expectations for pass, lane error, timeout, skip-gate, mask and reset.
module tb_rdlvl_initiator;

  logic       SCLK;
  logic       reset;
  logic       start_a, start_b;
  logic       rank_sel, skip_gate;
  logic [8:0] phy_resp, phy_err;
  logic       sel_b;

  logic       busy_a, done_a, fail_a, tmo_a;
  logic       busy_b, done_b, fail_b, tmo_b;
  logic [8:0] fl_a, fl_b;
  logic [15:0] rc_a, rc_b;
  logic [2:0] st_a, st_b;

  int n_errs;
  int n_checks;

  rdlvl_initiator_if #(.IOG_DQS_LANES(9)) if_a ();
  rdlvl_initiator_if #(.IOG_DQS_LANES(9)) if_b ();

  assign if_a.dfi_rdlvl_resp    = phy_resp;
  assign if_a.rd_training_error = phy_err;
  assign if_b.dfi_rdlvl_resp    = phy_resp;
  assign if_b.rd_training_error = phy_err;

  rdlvl_initiator #(
    .IOG_DQS_LANES(9), .LANE_MASK(32'h1FF), .RD_GAP(8), .TIMEOUT(16'd100), .SETTLE(4)
  ) dut_a (
    .SCLK(SCLK), .reset(reset), .start(start_a), .rank_sel(rank_sel), .skip_gate(skip_gate),
    .dfi(if_a.master), .busy(busy_a), .done(done_a), .fail(fail_a), .timeout_err(tmo_a),
    .fail_lanes(fl_a), .read_count(rc_a), .state_dbg(st_a)
  );

  rdlvl_initiator #(
    .IOG_DQS_LANES(9), .LANE_MASK(32'h0FF), .RD_GAP(8), .TIMEOUT(16'd100), .SETTLE(4)
  ) dut_b (
    .SCLK(SCLK), .reset(reset), .start(start_b), .rank_sel(rank_sel), .skip_gate(skip_gate),
    .dfi(if_b.master), .busy(busy_b), .done(done_b), .fail(fail_b), .timeout_err(tmo_b),
    .fail_lanes(fl_b), .read_count(rc_b), .state_dbg(st_b)
  );

  // Selected-DUT view.
  wire        s_gate  = sel_b ? if_b.dfi_rdlvl_gate_en : if_a.dfi_rdlvl_gate_en;
  wire        s_rdlvl = sel_b ? if_b.dfi_rdlvl_en      : if_a.dfi_rdlvl_en;
  wire        s_cs0   = sel_b ? if_b.dfi_rdlvl_cs_0_n  : if_a.dfi_rdlvl_cs_0_n;
  wire        s_cs1   = sel_b ? if_b.dfi_rdlvl_cs_1_n  : if_a.dfi_rdlvl_cs_1_n;
  wire        s_p0    = sel_b ? if_b.dfi_rddata_en_p0  : if_a.dfi_rddata_en_p0;
  wire        s_p1    = sel_b ? if_b.dfi_rddata_en_p1  : if_a.dfi_rddata_en_p1;
  wire        s_p2    = sel_b ? if_b.dfi_rddata_en_p2  : if_a.dfi_rddata_en_p2;
  wire        s_p3    = sel_b ? if_b.dfi_rddata_en_p3  : if_a.dfi_rddata_en_p3;
  wire        s_busy  = sel_b ? busy_b : busy_a;
  wire        s_done  = sel_b ? done_b : done_a;
  wire        s_fail  = sel_b ? fail_b : fail_a;
  wire        s_tmo   = sel_b ? tmo_b  : tmo_a;
  wire [8:0]  s_fl    = sel_b ? fl_b   : fl_a;
  wire [15:0] s_rc    = sel_b ? rc_b   : rc_a;
  wire [2:0]  s_st    = sel_b ? st_b   : st_a;

  // Monitor results of the last run_seq.
  int g_cyc, r_cyc, first_g, first_r, cs_bad, p_bad, busy_bad, done_cyc;

  // clock / reset
  initial begin
    SCLK = 1'b0;
    forever #5 SCLK = ~SCLK;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic rank, input logic skip);
    @(negedge SCLK);
    rank_sel  = rank;
    skip_gate = skip;
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge SCLK);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Steps the selected DUT cycle by cycle from phase entry, playing the PHY: all non-silent
  // lanes respond once the n-th read of a phase is seen. A start pulse is injected at restart_at.
  task automatic run_seq(input logic rank, input int n_g, input int n_r, input logic [8:0] err_g,
                         input logic [8:0] silent, input int restart_at, input int budget);
    int cyc, g_reads, r_reads;
    bit g_resp, r_resp;
    logic prev_p;
    cyc = 0; g_reads = 0; r_reads = 0; g_resp = 0; r_resp = 0; prev_p = 1'b0;
    g_cyc = 0; r_cyc = 0; first_g = -1; first_r = -1;
    cs_bad = 0; p_bad = 0; busy_bad = 0; done_cyc = -1;
    while (cyc < budget && done_cyc < 0) begin
      if (s_p0 != s_p1 || s_p0 != s_p2 || s_p0 != s_p3 || (s_p0 && prev_p)) p_bad++;
      prev_p = s_p0;
      if (s_cs0 != !((s_gate || s_rdlvl) && !rank)) cs_bad++;
      if (s_cs1 != !((s_gate || s_rdlvl) && rank)) cs_bad++;
      if (s_done) done_cyc = cyc;
      else if (!s_busy) busy_bad++;
      phy_resp = '0;
      phy_err  = '0;
      if (s_gate) begin
        if (s_p0) begin
          g_reads++;
          if (first_g < 0) first_g = g_cyc;
        end
        g_cyc++;
        if (g_reads == n_g && !g_resp) begin
          phy_resp = ~silent;
          phy_err  = err_g & ~silent;
          g_resp   = 1;
        end
      end
      if (s_rdlvl) begin
        if (s_p0) begin
          r_reads++;
          if (first_r < 0) first_r = r_cyc;
        end
        r_cyc++;
        if (r_reads == n_r && !r_resp) begin
          phy_resp = ~silent;
          r_resp   = 1;
        end
      end
      if (cyc == restart_at) begin
        rank_sel  = 1'b1;
        skip_gate = 1'b0;
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
      end else begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      if (done_cyc < 0) begin
        @(negedge SCLK);
        cyc++;
      end
    end
    start_a  = 1'b0;
    start_b  = 1'b0;
    phy_resp = '0;
    phy_err  = '0;
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_ctl"},
             {20'd0, s_gate, s_rdlvl, s_cs0, s_cs1, s_p0, s_p1, s_p2, s_p3,
              s_busy, s_done, s_fail, s_tmo}, 32'h300);
    check_eq({tag, "_fl"}, {23'd0, s_fl}, 32'h0);
    check_eq({tag, "_rc"}, {16'd0, s_rc}, 32'h0);
    check_eq({tag, "_st"}, {29'd0, s_st}, 32'h0);
  endtask

  task automatic check_protocol(input string tag);
    check_eq({tag, "_cs"}, cs_bad, 0);
    check_eq({tag, "_pulse"}, p_bad, 0);
    check_eq({tag, "_busy"}, busy_bad, 0);
  endtask

  initial begin
    n_errs = 0; n_checks = 0;
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; rank_sel = 1'b0; skip_gate = 1'b0;
    phy_resp = '0; phy_err = '0; sel_b = 1'b0;
    repeat (3) @(negedge SCLK);
    check_reset_outs("rst_a");
    sel_b = 1'b1;
    check_reset_outs("rst_b");
    sel_b = 1'b0;
    reset = 1'b0;

    // Normal pass, rank 0: 3 gate reads, 5 rdlvl reads.
    do_start(1'b0, 1'b0);
    run_seq(1'b0, 3, 5, 9'h000, 9'h000, -1, 300);
    check_eq("pass_done_cyc", done_cyc, 74);
    check_eq("pass_first_g", first_g, 8);
    check_eq("pass_first_r", first_r, 8);
    check_eq("pass_g_cyc", g_cyc, 25);
    check_eq("pass_r_cyc", r_cyc, 41);
    check_eq("pass_rc", {16'd0, s_rc}, 32'd8);
    check_eq("pass_flags", {29'd0, s_done, s_fail, s_tmo}, 32'b100);
    check_eq("pass_fl", {23'd0, s_fl}, 32'h0);
    check_eq("pass_st", {29'd0, s_st}, 32'd5);
    check_protocol("pass");

    // Lane 4 errors in gate phase, rank 1: rdlvl skipped.
    do_start(1'b1, 1'b0);
    run_seq(1'b1, 3, 5, 9'h010, 9'h000, -1, 300);
    check_eq("lerr_done_cyc", done_cyc, 29);
    check_eq("lerr_r_cyc", r_cyc, 0);
    check_eq("lerr_rc", {16'd0, s_rc}, 32'd3);
    check_eq("lerr_flags", {29'd0, s_done, s_fail, s_tmo}, 32'b110);
    check_eq("lerr_fl", {23'd0, s_fl}, 32'h010);
    check_protocol("lerr");

    // Timeout: lane 8 silent, TIMEOUT = 100.
    do_start(1'b0, 1'b0);
    run_seq(1'b0, 3, 5, 9'h000, 9'h100, -1, 300);
    check_eq("tmo_done_cyc", done_cyc, 100);
    check_eq("tmo_g_cyc", g_cyc, 100);
    check_eq("tmo_r_cyc", r_cyc, 0);
    check_eq("tmo_rc", {16'd0, s_rc}, 32'd12);
    check_eq("tmo_flags", {29'd0, s_done, s_fail, s_tmo}, 32'b111);
    check_protocol("tmo");

    // skip_gate with a second start while busy (asks for rank 1, gate); must be ignored.
    do_start(1'b0, 1'b1);
    run_seq(1'b0, 3, 5, 9'h000, 9'h000, 20, 300);
    check_eq("skip_done_cyc", done_cyc, 45);
    check_eq("skip_g_cyc", g_cyc, 0);
    check_eq("skip_first_r", first_r, 8);
    check_eq("skip_rc", {16'd0, s_rc}, 32'd5);
    check_eq("skip_flags", {29'd0, s_done, s_fail, s_tmo}, 32'b100);
    check_protocol("skip");
    repeat (20) @(negedge SCLK);
    check_eq("skip_hold", {28'd0, s_done, s_busy, s_gate, s_rdlvl}, 32'b1000);

    // LANE_MASK = 0FF on dut_b, lane 8 silent.
    sel_b = 1'b1;
    do_start(1'b0, 1'b0);
    run_seq(1'b0, 3, 5, 9'h000, 9'h100, -1, 300);
    check_eq("mask_done_cyc", done_cyc, 74);
    check_eq("mask_rc", {16'd0, s_rc}, 32'd8);
    check_eq("mask_flags", {29'd0, s_done, s_fail, s_tmo}, 32'b100);
    check_protocol("mask");
    sel_b = 1'b0;

    // Reset in the middle of RDLVL, then a full rerun.
    do_start(1'b0, 1'b0);
    run_seq(1'b0, 3, 99, 9'h000, 9'h000, -1, 40);
    check_eq("mid_rdlvl_en", {31'd0, s_rdlvl}, 32'd1);
    check_eq("mid_rc", {16'd0, s_rc}, 32'd4);
    #2 reset = 1'b1;
    #1 check_reset_outs("mid_rst");
    @(negedge SCLK);
    reset = 1'b0;
    do_start(1'b0, 1'b0);
    run_seq(1'b0, 3, 5, 9'h000, 9'h000, -1, 300);
    check_eq("rerun_done_cyc", done_cyc, 74);
    check_eq("rerun_rc", {16'd0, s_rc}, 32'd8);
    check_eq("rerun_flags", {29'd0, s_done, s_fail, s_tmo}, 32'b100);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/rdlvl_initiator.md
Name: rdlvl_initiator

Overview:
- Controller-side sequencer that drives the DFI read-training handshake into the PHY read-levelling state machines.
- Runs gate training, then read-eye levelling, for one selected rank.
- Issues periodic training reads and collects per-lane dfi_rdlvl_resp and per-lane error flags.
- Reports pass/fail, lane failures and read count to the training top level.

Parameters:
- IOG_DQS_LANES, 9, number of DQS lanes.
- LANE_MASK, 9'h1FF, lanes that must respond. Bit 0 = lane 0; only the low IOG_DQS_LANES bits are used.
- RD_GAP, 8, cycles between training-read pulses. Legal range 2..255.
- TIMEOUT, 16'hFFFF, maximum cycles per phase before failing.
- SETTLE, 4, idle cycles after each phase's enable deasserts.

Ports:
- SCLK  in  1  clock.
- reset  in  1  async active-high reset.
- start  in  1  one-cycle pulse; starts a training run when idle.
- rank_sel  in  1  0 = rank 0 (cs_0), 1 = rank 1 (cs_1). Sampled on an accepted start.
- skip_gate  in  1  1 = skip the gate phase. Sampled on an accepted start.
- dfi_rdlvl_gate_en  out  1  gate-training enable to PHY.
- dfi_rdlvl_en  out  1  read-levelling enable to PHY.
- dfi_rdlvl_cs_0_n  out  1  training chip select, rank 0, active low.
- dfi_rdlvl_cs_1_n  out  1  training chip select, rank 1, active low.
- dfi_rddata_en_p0..p3  out  1 each  training-read enables.
- dfi_rdlvl_resp  in  IOG_DQS_LANES  per-lane training-done from PHY.
- rd_training_error  in  IOG_DQS_LANES  per-lane error, valid with resp.
- busy  out  1  sequence in progress.
- done  out  1  sequence finished, pass or fail.
- fail  out  1  sequence failed.
- timeout_err  out  1  failure caused by timeout.
- fail_lanes  out  IOG_DQS_LANES  sticky per-lane error.
- read_count  out  16  reads issued in the current or last run; saturates at 16'hFFFF.

Behaviour:
- All outputs are registered. Reset is asynchronous, active high.
- Reset values:
  - All enables 0.
  - cs_0_n = cs_1_n = 1.
  - dfi_rddata_en_p* = 0.
  - busy, done, fail, timeout_err = 0.
  - fail_lanes = 0, read_count = 0.
  - FSM in IDLE.
- Assertion of reset mid-run aborts immediately to reset values; no drain.
- FSM states: IDLE, GATE, GATE_SETTLE, RDLVL, RDLVL_SETTLE, DONE.
- IDLE / DONE:
  - start is accepted only in IDLE or DONE; start in any other state is ignored.
  - On accept: latch rank_sel and skip_gate, clear done/fail/timeout_err/fail_lanes/read_count, set busy.
  - Next state is GATE, or RDLVL if skip_gate = 1.
- Phase entry (GATE or RDLVL), on the first cycle in the state:
  - The phase enable (dfi_rdlvl_gate_en or dfi_rdlvl_en) is 1.
  - The selected cs_n is 0; the other cs_n stays 1.
  - resp_seen is cleared, the gap counter is loaded with RD_GAP-1, and the phase timer is cleared.
- Read issue:
  - When the gap counter reaches 0 and (resp_seen & LANE_MASK) != LANE_MASK, dfi_rddata_en_p0..p3 all pulse high for exactly one cycle.
  - On the same cycle the gap counter reloads RD_GAP-1 and read_count increments (saturating).
  - The first pulse occurs RD_GAP cycles after phase entry.
  - No pulses once all masked lanes have responded.
- Response collection:
  - resp_seen |= dfi_rdlvl_resp on every cycle.
  - fail_lanes |= dfi_rdlvl_resp & rd_training_error on every cycle.
  - A resp and an error on the same cycle for a lane count as both responded and failed.
  - Unmasked lanes are ignored for completion but still recorded in fail_lanes.
- Phase complete when (resp_seen & LANE_MASK) == LANE_MASK:
  - Deassert the enable and cs_n on the next cycle and go to the settle state.
  - Settle lasts SETTLE cycles with everything idle.
  - GATE_SETTLE leads to RDLVL. RDLVL_SETTLE leads to DONE.
- Timeout:
  - The phase timer increments every cycle in GATE/RDLVL.
  - At TIMEOUT without completion: set timeout_err and fail, drop enables/cs, go to DONE. Settle is skipped.
- Lane errors:
  - If fail_lanes & LANE_MASK != 0 at the end of GATE_SETTLE, the RDLVL phase is skipped and the FSM goes to DONE.
  - At DONE entry, fail = |(fail_lanes & LANE_MASK) | timeout_err.
- In DONE: done = 1 and busy = 0. Results hold until the next accepted start or reset.
- busy = 1 in every state other than IDLE and DONE.

Test Plan:
- Normal pass, RD_GAP = 8, rank 0:
  - PHY asserts all 9 resp after 3 reads in the gate phase and 5 reads in the rdlvl phase.
  - Expect cs_0_n low / cs_1_n high throughout, first read at cycle 8 of each phase, read_count = 8, done = 1, fail = 0, fail_lanes = 0.
- Lane error, rank 1:
  - Lane 4 raises rd_training_error with its resp in the gate phase.
  - Expect dfi_rdlvl_en never asserted, fail = 1, fail_lanes = 9'h010, timeout_err = 0, cs_1_n used.
- Timeout, TIMEOUT = 100:
  - Lane 8 never responds.
  - Expect gate_en dropped after 100 cycles, timeout_err = 1, fail = 1, done = 1, read_count = 12.
- skip_gate = 1 plus a start pulse while busy:
  - Expect gate_en never asserted, the second start ignored, and a single run to pass.
- LANE_MASK = 9'h0FF:
  - Lane 8 silent.
  - Expect normal completion with fail = 0.
- Reset mid-RDLVL:
  - Expect all outputs at reset values on the reset edge.
  - A start after reset runs a full sequence with read_count restarting from 0.
